// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//   Branch resolution and prediction.
//   Resolves conditional branches and jumps, and keeps a PC-indexed table of
//   saturating counters (the BHT) that supplies taken/not-taken predictions to
//   fetch. Mispredictions are flagged back to the pipeline. Saturating
//   statistics count resolved conditional branches and mispredictions.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   LkValid, LkPC        lookup request from fetch
//   LkValidOut, LkTaken  lookup result, one cycle later
//   ResValid, ResPC      resolve request from execute
//   RURs1, RURs2         signed compare operands
//   BrOp                 [4] jump, [3] conditional branch, [2:0] funct3
//   ResPredTaken         prediction that was used for the resolving instruction
//   ResValidOut          resolve result valid, one cycle later
//   NextPCSrc            branch/jump actually taken
//   Mispredict           actual outcome differs from ResPredTaken
//   BranchCount          resolved conditional branches (saturating)
//   MispredCount         mispredicts (saturating)
// -----------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int PC_W        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 2,
   parameter int STAT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LkValid,
   input  logic [PC_W-1:0]   LkPC,
   output logic              LkValidOut,
   output logic              LkTaken,
   input  logic              ResValid,
   input  logic [PC_W-1:0]   ResPC,
   input  logic [XLEN-1:0]   RURs1,
   input  logic [XLEN-1:0]   RURs2,
   input  logic [4:0]        BrOp,
   input  logic              ResPredTaken,
   output logic              ResValidOut,
   output logic              NextPCSrc,
   output logic              Mispredict,
   output logic [STAT_W-1:0] BranchCount,
   output logic [STAT_W-1:0] MispredCount
);

   localparam int               IDX_W    = $clog2(BHT_ENTRIES);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   // Weakly not-taken: just below the taken half of the counter range.
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   // Word-aligned PCs: bits [1:0] never select an entry.
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] res_idx;
   assign lk_idx  = LkPC[IDX_W+1:2];
   assign res_idx = ResPC[IDX_W+1:2];

   // PC bits outside the index field are intentionally ignored.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{LkPC, ResPC};

   // ---------------------------------------------------------------------------
   // Outcome function
   // ---------------------------------------------------------------------------
   logic cmp;
   logic taken;
   logic cond_branch;
   logic mispred;

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cmp = 1'b0;
      case (BrOp[2:0])
         3'b000:  cmp = (RURs1 == RURs2);
         3'b001:  cmp = (RURs1 != RURs2);
         3'b100:  cmp = ($signed(RURs1) <  $signed(RURs2));
         3'b101:  cmp = ($signed(RURs1) >= $signed(RURs2));
         3'b110:  cmp = (RURs1 <  RURs2);
         3'b111:  cmp = (RURs1 >= RURs2);
         default: cmp = 1'b0;   // 010/011 are never taken
      endcase
   end

   // A set jump bit dominates: the instruction is a jump, not a branch.
   assign taken       = BrOp[4] | (BrOp[3] & cmp);
   assign cond_branch = BrOp[3] & ~BrOp[4];
   assign mispred     = (taken != ResPredTaken);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic              lk_valid_q,      lk_valid_d;
   logic              lk_taken_q,      lk_taken_d;
   logic              res_valid_q,     res_valid_d;
   logic              next_pc_src_q,   next_pc_src_d;
   logic              mispredict_q,    mispredict_d;
   logic [STAT_W-1:0] branch_count_q,  branch_count_d;
   logic [STAT_W-1:0] mispred_count_q, mispred_count_d;
   logic [CNT_W-1:0]  bht_q [BHT_ENTRIES];
   logic [CNT_W-1:0]  bht_d [BHT_ENTRIES];

   always_comb begin
      lk_valid_d      = LkValid;
      lk_taken_d      = lk_taken_q;
      res_valid_d     = ResValid;
      next_pc_src_d   = next_pc_src_q;
      mispredict_d    = 1'b0;
      branch_count_d  = branch_count_q;
      mispred_count_d = mispred_count_q;
      bht_d           = bht_q;

      // Lookup reads the current table, so a same-cycle update to the same
      // entry is seen only by later lookups.
      if (LkValid) begin
         lk_taken_d = bht_q[lk_idx][CNT_W-1];
      end

      if (ResValid) begin
         next_pc_src_d = taken;
         mispredict_d  = mispred;

         if (mispred && (mispred_count_q != STAT_MAX)) begin
            mispred_count_d = mispred_count_q + STAT_W'(1);
         end

         if (cond_branch) begin
            if (branch_count_q != STAT_MAX) begin
               branch_count_d = branch_count_q + STAT_W'(1);
            end
            if (taken) begin
               if (bht_q[res_idx] != CNT_MAX) begin
                  bht_d[res_idx] = bht_q[res_idx] + CNT_W'(1);
               end
            end else if (bht_q[res_idx] != '0) begin
               bht_d[res_idx] = bht_q[res_idx] - CNT_W'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         lk_valid_q      <= 1'b0;
         lk_taken_q      <= 1'b0;
         res_valid_q     <= 1'b0;
         next_pc_src_q   <= 1'b0;
         mispredict_q    <= 1'b0;
         branch_count_q  <= '0;
         mispred_count_q <= '0;
         // NOTE: the table is built from flops rather than a RAM macro because
         // every entry must return to its initial value in the reset cycle.
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= CNT_INIT;
         end
      end else begin
         lk_valid_q      <= lk_valid_d;
         lk_taken_q      <= lk_taken_d;
         res_valid_q     <= res_valid_d;
         next_pc_src_q   <= next_pc_src_d;
         mispredict_q    <= mispredict_d;
         branch_count_q  <= branch_count_d;
         mispred_count_q <= mispred_count_d;
         bht_q           <= bht_d;
      end
   end

   assign LkValidOut   = lk_valid_q;
   assign LkTaken      = lk_taken_q;
   assign ResValidOut  = res_valid_q;
   assign NextPCSrc    = next_pc_src_q;
   assign Mispredict   = mispredict_q;
   assign BranchCount  = branch_count_q;
   assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//   Scoreboard bench for branch_predict_unit. The driver computes expected
//   results from a behavioural model (integer counters, clamped arithmetic)
//   and queues them; a monitor pops and compares whenever the DUT presents a
//   valid result. A narrow statistics width makes counter saturation reachable.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

   localparam int XLEN        = 32;
   localparam int PC_W        = 32;
   localparam int BHT_ENTRIES = 64;
   localparam int CNT_W       = 2;
   localparam int STAT_W      = 4;
   localparam int CNT_TOP     = (1 << CNT_W) - 1;
   localparam int CNT_HALF    = 1 << (CNT_W - 1);
   localparam int STAT_TOP    = (1 << STAT_W) - 1;

   logic              clk;
   logic              rst;
   logic              LkValid;
   logic [PC_W-1:0]   LkPC;
   logic              LkValidOut;
   logic              LkTaken;
   logic              ResValid;
   logic [PC_W-1:0]   ResPC;
   logic [XLEN-1:0]   RURs1;
   logic [XLEN-1:0]   RURs2;
   logic [4:0]        BrOp;
   logic              ResPredTaken;
   logic              ResValidOut;
   logic              NextPCSrc;
   logic              Mispredict;
   logic [STAT_W-1:0] BranchCount;
   logic [STAT_W-1:0] MispredCount;

   branch_predict_unit #(
      .XLEN(XLEN), .PC_W(PC_W), .BHT_ENTRIES(BHT_ENTRIES),
      .CNT_W(CNT_W), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .LkValid(LkValid), .LkPC(LkPC),
      .LkValidOut(LkValidOut), .LkTaken(LkTaken),
      .ResValid(ResValid), .ResPC(ResPC),
      .RURs1(RURs1), .RURs2(RURs2), .BrOp(BrOp),
      .ResPredTaken(ResPredTaken),
      .ResValidOut(ResValidOut), .NextPCSrc(NextPCSrc),
      .Mispredict(Mispredict),
      .BranchCount(BranchCount), .MispredCount(MispredCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit npc;
      bit misp;
      int bc;
      int mc;
   } res_exp_t;

   bit       lk_q[$];
   res_exp_t res_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int cnt[BHT_ENTRIES];
   int m_bc;
   int m_mc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % BHT_ENTRIES);
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic bit model_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int      sa, sb;
      longint  ua, ub;
      sa = int'(a);
      sb = int'(b);
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      if (op[4]) return 1'b1;
      if (!op[3]) return 1'b0;
      case (op[2:0])
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return ua < ub;
         3'd7: return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] = CNT_HALF - 1;
      m_bc = 0;
      m_mc = 0;
   endtask

   // One cycle of stimulus: drive, queue expectations, advance model, clock.
   task automatic drive(input bit lk_v, input logic [31:0] lk_pc,
                        input bit res_v, input logic [31:0] res_pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input bit pred);
      bit t;
      bit m;
      int i;
      rst          = 1'b0;
      LkValid      = lk_v;
      LkPC         = lk_pc;
      ResValid     = res_v;
      ResPC        = res_pc;
      RURs1        = a;
      RURs2        = b;
      BrOp         = op;
      ResPredTaken = pred;
      // The lookup sees the table as it was before this cycle's update.
      if (lk_v) lk_q.push_back(cnt[idx_of(lk_pc)] >= CNT_HALF);
      if (res_v) begin
         t = model_taken(op, a, b);
         m = (t != pred);
         if (m) m_mc = clamp(m_mc + 1, 0, STAT_TOP);
         if (op[4:3] == 2'b01) begin
            m_bc   = clamp(m_bc + 1, 0, STAT_TOP);
            i      = idx_of(res_pc);
            cnt[i] = clamp(cnt[i] + (t ? 1 : -1), 0, CNT_TOP);
         end
         res_q.push_back('{npc: t, misp: m, bc: m_bc, mc: m_mc});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic lookup(input logic [31:0] pc);
      drive(1'b1, pc, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input bit pred);
      drive(1'b0, 32'd0, 1'b1, pc, a, b, op, pred);
   endtask

   // Reset cycle with both requests asserted: they must be dropped.
   task automatic reset_dut();
      rst          = 1'b1;
      LkValid      = 1'b1;
      LkPC         = 32'h40;
      ResValid     = 1'b1;
      ResPC        = 32'h40;
      RURs1        = 32'd7;
      RURs2        = 32'd7;
      BrOp         = 5'b01000;
      ResPredTaken = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      LkValid  = 1'b0;
      ResValid = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   bit       armed    = 1'b0;
   bit       saw_rst  = 1'b0;
   bit       last_npc = 1'b0;
   bit       last_lk  = 1'b0;
   bit       exp_lk;
   res_exp_t exp_res;

   initial begin
      forever begin
         @(posedge clk);
         saw_rst = rst;
         @(negedge clk);
         if (saw_rst) begin
            armed    = 1'b1;
            last_npc = 1'b0;
            last_lk  = 1'b0;
            check("rst_lk_valid",   64'(LkValidOut),   64'd0);
            check("rst_lk_taken",   64'(LkTaken),      64'd0);
            check("rst_res_valid",  64'(ResValidOut),  64'd0);
            check("rst_npc",        64'(NextPCSrc),    64'd0);
            check("rst_mispredict", 64'(Mispredict),   64'd0);
            check("rst_branch_cnt", 64'(BranchCount),  64'd0);
            check("rst_mispred_cnt", 64'(MispredCount), 64'd0);
         end else if (armed) begin
            if (LkValidOut) begin
               if (lk_q.size() == 0) begin
                  check("lk_unexpected_valid", 64'(LkValidOut), 64'd0);
               end else begin
                  exp_lk = lk_q.pop_front();
                  check("lk_taken", 64'(LkTaken), 64'(exp_lk));
                  last_lk = exp_lk;
               end
            end else begin
               check("lk_taken_hold", 64'(LkTaken), 64'(last_lk));
            end
            if (ResValidOut) begin
               if (res_q.size() == 0) begin
                  check("res_unexpected_valid", 64'(ResValidOut), 64'd0);
               end else begin
                  exp_res = res_q.pop_front();
                  check("next_pc_src",  64'(NextPCSrc),    64'(exp_res.npc));
                  check("mispredict",   64'(Mispredict),   64'(exp_res.misp));
                  check("branch_count", 64'(BranchCount),  64'(exp_res.bc));
                  check("mispred_count", 64'(MispredCount), 64'(exp_res.mc));
                  last_npc = exp_res.npc;
               end
            end else begin
               check("npc_hold",        64'(NextPCSrc),  64'(last_npc));
               check("mispredict_idle", 64'(Mispredict), 64'd0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      rst = 1'b1; LkValid = 1'b0; LkPC = '0; ResValid = 1'b0; ResPC = '0;
      RURs1 = '0; RURs2 = '0; BrOp = '0; ResPredTaken = 1'b0;
      @(posedge clk);
      #1;
      reset_dut();

      // Every entry starts weakly not-taken.
      for (int i = 0; i < BHT_ENTRIES; i++) lookup(32'(i * 4));

      // BEQ equal three times at 0x40 with concurrent lookups (read-before-write),
      // then a lookup, then a not-taken resolve to confirm saturation at the top.
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h40, 1'b1, 32'h40, 32'd5, 32'd5, 5'b01000, 1'b0);
      lookup(32'h40);
      resolve(32'h40, 32'd5, 32'd5, 5'b01001, 1'b1);
      lookup(32'h40);

      // Signed versus unsigned comparisons.
      resolve(32'hC0, 32'hFFFF_FFFF, 32'd1, 5'b01100, 1'b0);
      resolve(32'hC4, 32'hFFFF_FFFF, 32'd1, 5'b01110, 1'b0);
      resolve(32'hC8, 32'hFFFF_FFFF, 32'd1, 5'b01111, 1'b0);
      resolve(32'hCC, 32'hFFFF_FFFF, 32'd1, 5'b01101, 1'b1);

      // Jump: taken, mispredicted, no branch count, table untouched.
      resolve(32'h44, 32'd1, 32'd2, 5'b10000, 1'b0);
      resolve(32'h44, 32'd1, 32'd1, 5'b11000, 1'b1);
      lookup(32'h44);
      // Neither jump nor branch: not taken, no update.
      resolve(32'h48, 32'd3, 32'd3, 5'b00000, 1'b1);
      lookup(32'h48);

      // Same-cycle lookup and update at 0x80, then a fresh lookup.
      drive(1'b1, 32'h80, 1'b1, 32'h80, 32'd9, 32'd9, 5'b01000, 1'b0);
      lookup(32'h80);
      // funct3 010 as a conditional branch: not taken, counter decrements.
      resolve(32'h80, 32'd9, 32'd9, 5'b01010, 1'b0);
      lookup(32'h80);

      // Bottom saturation via an aliasing PC (0x100 maps to entry 0).
      resolve(32'h100, 32'd1, 32'd1, 5'b01001, 1'b0);
      resolve(32'h000, 32'd1, 32'd1, 5'b01001, 1'b0);
      resolve(32'h102, 32'd1, 32'd1, 5'b01000, 1'b1);
      lookup(32'h0);
      resolve(32'h0, 32'd1, 32'd1, 5'b01000, 1'b1);
      lookup(32'h3);

      // Reset with a resolve in flight, then sweep the table.
      resolve(32'h40, 32'd2, 32'd2, 5'b01000, 1'b0);
      reset_dut();
      for (int i = 0; i < BHT_ENTRIES; i++) lookup(32'(i * 4));
      resolve(32'h40, 32'd2, 32'd2, 5'b01000, 1'b0);
      lookup(32'h40);

      // Randomised traffic over a small aliased PC pool.
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_dut();
         end else begin
            pc = (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3) | (32'($urandom_range(0, 1)) << 8);
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? ~a : $urandom);
            drive(1'($urandom), (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8),
                  1'($urandom), pc, a, b, 5'($urandom_range(0, 31)), 1'($urandom));
         end
      end

      idle(3);
      check("lk_queue_drained",  64'(lk_q.size()),  64'd0);
      check("res_queue_drained", 64'(res_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
